// File: rtl/h_receiver.sv
// Receive side of the H-bridge lane driver: synchronises both raw lanes, qualifies
// and locks onto the single active lane, and merges it back into one registered bit.

module h_lane_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic e
);
  logic [STAGES-1:0] chain;
  logic              s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      s_d   <= chain[STAGES-1];
    end
  end

  assign s = chain[STAGES-1];
  assign e = s ^ s_d;
endmodule

module h_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int ACT_EDGES    = 4,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in1,
  input  logic in2,
  input  logic clr_err,
  output logic out,
  output logic out_valid,
  output logic sel,
  output logic locked,
  output logic conflict
);
  localparam int NUM_LANES = 2;
  localparam int EW = $clog2(ACT_EDGES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, QUAL1, QUAL2, LOCK1, LOCK2} state_t;

  logic [NUM_LANES-1:0] raw, s, e;
  state_t               state;
  logic [EW-1:0]        edge_cnt;
  logic [IW-1:0]        idle_cnt;
  logic                 lane, own_e, oth_e, new_lane, conf_set, timeout;

  assign raw = {in2, in1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    h_lane_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .din (raw[g]),
      .s   (s[g]),
      .e   (e[g])
    );
  end

  // Lane index the FSM currently follows; bit 1 of e picks the lane on first edge.
  assign lane     = (state == QUAL2) || (state == LOCK2);
  assign own_e    = e[lane];
  assign oth_e    = e[~lane];
  assign new_lane = e[1];
  assign timeout  = (idle_cnt == IW'(IDLE_TIMEOUT - 1));
  assign conf_set = en && ((state == IDLE) ? (&e) : oth_e);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      idle_cnt  <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      sel       <= 1'b0;
      locked    <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      conflict  <= conf_set | (conflict & ~clr_err);
      out       <= 1'b0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        edge_cnt <= '0;
        idle_cnt <= '0;
        sel      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            edge_cnt <= '0;
            idle_cnt <= '0;
            if (^e) begin
              if (ACT_EDGES == 1) begin
                state     <= new_lane ? LOCK2 : LOCK1;
                sel       <= new_lane;
                out       <= s[new_lane];
                out_valid <= 1'b1;
                locked    <= 1'b1;
              end else begin
                state    <= new_lane ? QUAL2 : QUAL1;
                edge_cnt <= EW'(1);
              end
            end
          end
          QUAL1, QUAL2: begin
            if (oth_e) begin
              state    <= IDLE;
              edge_cnt <= '0;
              idle_cnt <= '0;
            end else if (own_e) begin
              if (edge_cnt == EW'(ACT_EDGES - 1)) begin
                state     <= lane ? LOCK2 : LOCK1;
                edge_cnt  <= '0;
                idle_cnt  <= '0;
                sel       <= lane;
                out       <= s[lane];
                out_valid <= 1'b1;
                locked    <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
                idle_cnt <= '0;
              end
            end else if (timeout) begin
              state    <= IDLE;
              edge_cnt <= '0;
              idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_TIMEOUT)) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          LOCK1, LOCK2: begin
            // Other-lane activity only raises conflict; lock is kept.
            if (!own_e && timeout) begin
              state    <= IDLE;
              edge_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              if (own_e)
                idle_cnt <= '0;
              else if (idle_cnt != IW'(IDLE_TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
              out       <= s[lane];
              out_valid <= 1'b1;
              locked    <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            edge_cnt <= '0;
            idle_cnt <= '0;
          end
        endcase
      end
    end
  end
endmodule
